// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes, mux selects, trap causes.
// Pure definitions; no timing or flow-control content.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_R_EXEC,
        S_R_WB,
        S_ADDI_EXEC,
        S_ADDI_WB,
        S_MEM_ADDR,
        S_LW_MEM,
        S_LW_WB,
        S_SW_MEM,
        S_BEQ,
        S_JUMP,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BR   = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // States that hold a memory request open and are therefore guarded by the wait timer.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_LW_MEM) || (s == S_SW_MEM);
    endfunction

endpackage

// File: rtl/mcu_wait_timer.sv
// Counts consecutive not-ready cycles of a memory request; expired is combinational on the limit cycle.
// Zero latency on expired; no backpressure (clr has priority over inc).
module mcu_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    import mcu_pkg::*;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The TIMEOUT-th idle cycle is the one seen with cnt == TIMEOUT-1; a ready in that cycle wins.
    assign expired = inc && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style multi-cycle MIPS controller with illegal-opcode / memory-timeout trap and retire counter.
// Outputs decode from state (ir_write/pc_write also qualify on mem_ready in FETCH); memory states stall on mem_ready.
module multicycle_control_unit #(
    parameter int OPC_W   = 6,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32,
    parameter bit ADDI_EN = 1'b1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_2_reg,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);
    import mcu_pkg::*;

    state_t     state, next_state;
    logic [1:0] cause_q, cause_d;
    logic       retire;
    logic       in_mem;
    logic       tmr_expired;

    assign in_mem = is_mem_state(state);

    mcu_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .arst_n  (arst_n),
        .clr     (!in_mem || mem_ready),
        .inc     (in_mem && !mem_ready),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_IDLE;
            cause_q     <= CAUSE_NONE;
            instr_count <= '0;
        end else begin
            state   <= next_state;
            cause_q <= cause_d;
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        next_state    = state;
        cause_d       = cause_q;
        retire        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_2_reg     = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (tmr_expired) begin
                    next_state = S_TRAP;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_BR;
                if (opcode == OPC_W'(OP_R)) begin
                    next_state = S_R_EXEC;
                end else if (ADDI_EN && (opcode == OPC_W'(OP_ADDI))) begin
                    next_state = S_ADDI_EXEC;
                end else if ((opcode == OPC_W'(OP_LW)) || (opcode == OPC_W'(OP_SW))) begin
                    next_state = S_MEM_ADDR;
                end else if (opcode == OPC_W'(OP_BEQ)) begin
                    next_state = S_BEQ;
                end else if (opcode == OPC_W'(OP_J)) begin
                    next_state = S_JUMP;
                end else begin
                    next_state = S_TRAP;
                    cause_d    = CAUSE_ILLEGAL;
                end
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNCT;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_ADDI_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = (opcode == OPC_W'(OP_SW)) ? S_SW_MEM : S_LW_MEM;
            end
            S_LW_MEM: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_state = S_LW_WB;
                end else if (tmr_expired) begin
                    next_state = S_TRAP;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            S_LW_WB: begin
                reg_write = 1'b1;
                mem_2_reg = 1'b1;
                retire    = 1'b1;
            end
            S_SW_MEM: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                end else if (tmr_expired) begin
                    next_state = S_TRAP;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // run is only consulted at an instruction boundary.
        if (retire) next_state = run ? S_FETCH : S_IDLE;
    end

    assign trap       = (state == S_TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised instruction-stream bench: per-cycle expected control words are queued by the driver
// from an instruction-level model and compared by an independent negedge monitor.
module tb_multicycle_control_unit;

    localparam int TO = 4;

    typedef struct packed {
        logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
        logic [1:0]  pc_source, alu_op;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic        reg_write, reg_dst, mem_2_reg, trap;
        logic [1:0]  trap_cause;
        logic [31:0] cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  opcode = '0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_source, alu_op, alu_src_b, trap_cause;
    logic        alu_src_a, reg_write, reg_dst, mem_2_reg, trap;
    logic [31:0] instr_count;

    logic        run_2 = 1'b0;
    logic [5:0]  opcode_2 = '0;
    logic        mem_ready_2 = 1'b0;
    logic        mem_read_2, mem_write_2, i_or_d_2, ir_write_2, pc_write_2, pc_write_cond_2;
    logic [1:0]  pc_source_2, alu_op_2, alu_src_b_2, trap_cause_2;
    logic        alu_src_a_2, reg_write_2, reg_dst_2, mem_2_reg_2, trap_2;
    logic [31:0] instr_count_2;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPC_W(6), .TIMEOUT(TO), .CNT_W(32), .ADDI_EN(1'b1)) dut (
        .clk(clk), .arst_n(arst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_2_reg(mem_2_reg), .trap(trap), .trap_cause(trap_cause),
        .instr_count(instr_count)
    );

    multicycle_control_unit #(.OPC_W(6), .TIMEOUT(TO), .CNT_W(32), .ADDI_EN(1'b0)) dut_noaddi (
        .clk(clk), .arst_n(arst_n), .run(run_2), .opcode(opcode_2), .mem_ready(mem_ready_2),
        .mem_read(mem_read_2), .mem_write(mem_write_2), .i_or_d(i_or_d_2), .ir_write(ir_write_2),
        .pc_write(pc_write_2), .pc_write_cond(pc_write_cond_2), .pc_source(pc_source_2),
        .alu_op(alu_op_2), .alu_src_a(alu_src_a_2), .alu_src_b(alu_src_b_2), .reg_write(reg_write_2),
        .reg_dst(reg_dst_2), .mem_2_reg(mem_2_reg_2), .trap(trap_2), .trap_cause(trap_cause_2),
        .instr_count(instr_count_2)
    );

    obs_t got;
    assign got = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                  alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_2_reg, trap, trap_cause,
                  instr_count};

    int    checks = 0;
    int    failures = 0;
    obs_t  exp_q[$];
    string tag_q[$];
    string phase = "init";
    int    mcount = 0;
    bit    in_idle = 1'b1;

    task automatic check(input string name, input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, g, e);
        end
    endtask

    task automatic check_val(input string name, input int g, input int e);
        checks++;
        if (g != e) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, g, e);
        end
    endtask

    // Monitor: one expected control word per cycle the driver has scheduled.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, got, e);
        end
    end

    task automatic step(input logic r, input logic [5:0] op, input logic rdy, input obs_t e);
        run = r;
        opcode = op;
        mem_ready = rdy;
        e.cnt = mcount;
        exp_q.push_back(e);
        tag_q.push_back(phase);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic do_reset();
        obs_t z;
        z = '0;
        run = 1'b0;
        arst_n = 1'b0;
        #1;
        check({phase, "_reset_async"}, got, z);
        @(posedge clk);
        #1;
        check({phase, "_reset_hold"}, got, z);
        arst_n = 1'b1;
        mcount = 0;
        in_idle = 1'b1;
    endtask

    task automatic trap_hold(input logic [1:0] cause, input int n);
        obs_t e;
        e = '0;
        e.trap = 1'b1;
        e.trap_cause = cause;
        for (int i = 0; i < n; i++) step(rb(), 6'($urandom), rb(), e);
        do_reset();
    endtask

    // Waits lat not-ready cycles then one ready cycle; false if the timeout limit is hit first.
    task automatic mem_phase(input int lat, input logic [5:0] op, input obs_t base, input bit fetch,
                             input bit retire_here, input bit run_next, output bit ok);
        obs_t e;
        for (int i = 0; i < lat && i < TO; i++) step(rb(), op, 1'b0, base);
        ok = (lat < TO);
        if (ok) begin
            e = base;
            if (fetch) begin
                e.pc_write = 1'b1;
                e.ir_write = 1'b1;
            end
            step(retire_here ? run_next : rb(), op, 1'b1, e);
        end
    endtask

    task automatic retire_step(input logic [5:0] op, input obs_t e, input bit run_next);
        step(run_next, op, rb(), e);
        mcount++;
        in_idle = !run_next;
    endtask

    task automatic run_instr(input logic [5:0] op, input int flat, input int mlat,
                             input bit run_next, input int hold);
        obs_t e;
        bit   ok;
        if (in_idle) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 6'($urandom), rb(), '0);
            step(1'b1, 6'($urandom), rb(), '0);
        end
        e = '0;
        e.mem_read = 1'b1;
        e.alu_src_b = 2'd1;
        mem_phase(flat, 6'($urandom), e, 1'b1, 1'b0, 1'b0, ok);
        if (!ok) begin
            trap_hold(2'd2, hold);
            return;
        end
        e = '0;
        e.alu_src_b = 2'd3;
        step(rb(), op, rb(), e);
        case (op)
            6'h00: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'd2;
                step(rb(), op, rb(), e);
                e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
                retire_step(op, e, run_next);
            end
            6'h08: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                step(rb(), op, rb(), e);
                e = '0; e.reg_write = 1'b1;
                retire_step(op, e, run_next);
            end
            6'h23, 6'h2B: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                step(rb(), op, rb(), e);
                e = '0; e.i_or_d = 1'b1;
                if (op == 6'h23) e.mem_read = 1'b1;
                else e.mem_write = 1'b1;
                mem_phase(mlat, op, e, 1'b0, op == 6'h2B, run_next, ok);
                if (!ok) begin
                    trap_hold(2'd2, hold);
                end else if (op == 6'h2B) begin
                    mcount++;
                    in_idle = !run_next;
                end else begin
                    e = '0; e.reg_write = 1'b1; e.mem_2_reg = 1'b1;
                    retire_step(op, e, run_next);
                end
            end
            6'h04: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_write_cond = 1'b1; e.pc_source = 2'd1;
                retire_step(op, e, run_next);
            end
            6'h02: begin
                e = '0; e.pc_write = 1'b1; e.pc_source = 2'd2;
                retire_step(op, e, run_next);
            end
            default: trap_hold(2'd1, hold);
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] optab [8];
        optab = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h00};

        @(posedge clk);
        #1;
        check("reset_state", got, '0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADDI_EN=0 instance: one R-type retires, then ADDI traps as illegal.
        run_2 = 1'b1; mem_ready_2 = 1'b1; opcode_2 = 6'h00;
        repeat (5) @(posedge clk);
        #1;
        opcode_2 = 6'h08;
        repeat (6) @(posedge clk);
        #1;
        check_val("noaddi_trap", int'(trap_2), 1);
        check_val("noaddi_cause", int'(trap_cause_2), 1);
        check_val("noaddi_count", int'(instr_count_2), 1);
        check_val("noaddi_ctrl_off", int'({mem_read_2, pc_write_2, reg_write_2, alu_src_b_2}), 0);
        run_2 = 1'b0;

        phase = "r_type";   run_instr(6'h00, 0, 0, 1'b1, 2);
        phase = "lw_slow";  run_instr(6'h23, 3, 3, 1'b1, 2);
        phase = "addi";     run_instr(6'h08, 0, 0, 1'b1, 2);
        phase = "sw_edge";  run_instr(6'h2B, 1, TO - 1, 1'b1, 2);
        phase = "beq";      run_instr(6'h04, 2, 0, 1'b1, 2);
        phase = "jump";     run_instr(6'h02, 0, 0, 1'b0, 2);
        phase = "idle";     step(1'b0, 6'h00, 1'b1, '0);
        check_val("count_after_jump", int'(instr_count), 6);
        phase = "illegal";  run_instr(6'h3F, 0, 0, 1'b1, 20);
        phase = "sw_tmo";   run_instr(6'h2B, 0, TO, 1'b1, 3);
        phase = "fetch_tmo"; run_instr(6'h00, TO, 0, 1'b1, 3);

        begin
            obs_t e;
            phase = "mid_reset";
            step(1'b1, 6'h00, 1'b0, '0);
            e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'd1; e.pc_write = 1'b1; e.ir_write = 1'b1;
            step(1'b1, 6'h00, 1'b1, e);
            e = '0; e.alu_src_b = 2'd3;
            step(1'b1, 6'h00, 1'b0, e);
            do_reset();
        end

        phase = "random";
        for (int n = 0; n < 200; n++) begin
            int         idx;
            logic [5:0] op;
            int         fl;
            int         ml;
            idx = $urandom_range(0, 7);
            op = optab[idx];
            if (idx == 7) op = 6'($urandom);
            fl = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1);
            ml = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1);
            run_instr(op, fl, ml, $urandom_range(0, 3) != 0, 2);
        end

        repeat (2) @(negedge clk);
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
